debug_scan_master: RTL and testbench

- Host-side master for the core's single-step debug port.
- Drives debug_en, debug_step and debug_addr into the core, and samples the returned debug_data.
- Accepts a command over a valid/ready channel: halt, run, step, or scan. A scan walks the register-file debug addresses and streams each (addr, data) pair out on a valid/ready channel toward a UART/display formatter.
- Sits between the board-level command source and the RV32 core top.

---
 rtl/dbg_pkg.sv | 21 ++
 rtl/dbg_step_pulser.sv | 53 +++++
 rtl/debug_scan_master.sv | 139 +++++++++++++
 tb/tb_debug_scan_master.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared encodings for the debug scan master: command opcodes, FSM states
// and the base addresses of the register and test-signal debug windows.
package dbg_pkg;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_SCAN = 2'b11;

    localparam logic [6:0] DBG_REG_BASE  = 7'd0;
    localparam logic [6:0] DBG_TEST_BASE = 7'd32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STEP_HI = 3'd1,
        ST_STEP_LO = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_OUT     = 3'd4
    } state_e;

endpackage

// File: rtl/dbg_step_pulser.sv
// High/low step pulse generator: on start_i drives pulse_o high for STEP_PULSE
// cycles, then low for STEP_PULSE cycles, flagging the end of each phase.
module dbg_step_pulser #(
    parameter int STEP_PULSE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic pulse_o,
    output logic hi_end_o,
    output logic done_o
);

    localparam int CW = (STEP_PULSE > 1) ? $clog2(STEP_PULSE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_PULSE - 1);

    logic          active_q;
    logic          lo_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    assign pulse_o  = pulse_q;
    assign hi_end_o = active_q && !lo_q && (cnt_q == CNT_LAST);
    assign done_o   = active_q &&  lo_q && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            lo_q     <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (!active_q) begin
            if (start_i) begin
                active_q <= 1'b1;
                lo_q     <= 1'b0;
                pulse_q  <= 1'b1;
                cnt_q    <= '0;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (!lo_q) begin
                lo_q    <= 1'b1;
                pulse_q <= 1'b0;
            end else begin
                active_q <= 1'b0;
                lo_q     <= 1'b0;
            end
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/debug_scan_master.sv
// Host-side master for the core's single-step debug port: halt/run/step/scan.
// Define DBG_TEST_SCAN_EN to extend each scan over the test-signal window.
module debug_scan_master
    import dbg_pkg::*;
#(
    parameter int NUM_REGS      = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int STEP_PULSE    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    output logic        debug_en,
    output logic        debug_step,
    output logic [6:0]  debug_addr,
    input  logic [31:0] debug_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_addr,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output state_e      dbg_state
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);
    localparam logic [6:0] REG_LAST = DBG_REG_BASE + 7'(NUM_REGS - 1);

    state_e        state_q;
    logic          debug_en_q;
    logic [6:0]    addr_q;
    logic [6:0]    addr_d;
    logic [SW-1:0] settle_q;
    logic          out_valid_q;
    logic [6:0]    out_addr_q;
    logic [31:0]   out_data_q;
    logic          out_last_q;
    logic          cmd_fire;
    logic          step_start;
    logic          hi_end;
    logic          step_done;

`ifdef DBG_TEST_SCAN_EN
    localparam logic [6:0] SCAN_LAST = DBG_TEST_BASE + 7'(NUM_REGS - 1);
    // The register window hands over to the test-signal window.
    assign addr_d = (addr_q == REG_LAST) ? DBG_TEST_BASE : addr_q + 7'd1;
`else
    localparam logic [6:0] SCAN_LAST = REG_LAST;
    assign addr_d = addr_q + 7'd1;
`endif

    assign cmd_ready  = (state_q == ST_IDLE);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign step_start = cmd_fire && (cmd_op == OP_STEP) && debug_en_q;

    assign busy       = (state_q != ST_IDLE);
    assign dbg_state  = state_q;
    assign debug_en   = debug_en_q;
    assign debug_addr = addr_q;
    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;

    dbg_step_pulser #(
        .STEP_PULSE(STEP_PULSE)
    ) u_pulser (
        .clk     (clk),
        .rst     (rst),
        .start_i (step_start),
        .pulse_o (debug_step),
        .hi_end_o(hi_end),
        .done_o  (step_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            debug_en_q  <= 1'b0;
            addr_q      <= '0;
            settle_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        case (cmd_op)
                            OP_HALT: debug_en_q <= 1'b1;
                            OP_RUN:  debug_en_q <= 1'b0;
                            OP_STEP: if (debug_en_q) state_q <= ST_STEP_HI;
                            OP_SCAN: begin
                                addr_q   <= DBG_REG_BASE;
                                settle_q <= '0;
                                state_q  <= ST_SETTLE;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_STEP_HI: if (hi_end) state_q <= ST_STEP_LO;
                ST_STEP_LO: if (step_done) state_q <= ST_IDLE;
                ST_SETTLE: begin
                    // debug_addr has been stable long enough; sample the core.
                    if (settle_q == SETTLE_LAST) begin
                        out_valid_q <= 1'b1;
                        out_addr_q  <= addr_q;
                        out_data_q  <= debug_data;
                        out_last_q  <= (addr_q == SCAN_LAST);
                        state_q     <= ST_OUT;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            out_last_q <= 1'b0;
                            addr_q     <= '0;
                            state_q    <= ST_IDLE;
                        end else begin
                            addr_q   <= addr_d;
                            settle_q <= '0;
                            state_q  <= ST_SETTLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_scan_master.sv
// Directed bench for debug_scan_master: reset, halt/run, step pulses,
// full and back-pressured scans, and reset in the middle of a scan.
module tb_debug_scan_master;
    import dbg_pkg::*;

    localparam int NUM_REGS      = 32;
    localparam int SETTLE_CYCLES = 2;
    localparam int STEP_PULSE    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic        debug_en;
    logic        debug_step;
    logic [6:0]  debug_addr;
    logic [31:0] debug_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    state_e      dbg_state;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];

    debug_scan_master #(
        .NUM_REGS     (NUM_REGS),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .STEP_PULSE   (STEP_PULSE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .debug_en  (debug_en),
        .debug_step(debug_step),
        .debug_addr(debug_addr),
        .debug_data(debug_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Core model: register-file read data tagged with its address.
    assign debug_data = 32'hA500_0000 | {25'd0, debug_addr};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        check("cmd_ready_before_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic watch_step(output logic [11:0] step_v, output logic [11:0] busy_v);
        step_v = '0;
        busy_v = '0;
        for (int i = 0; i < 12; i++) begin
            step_v[i] = debug_step;
            busy_v[i] = busy;
            tick();
        end
    endtask

    task automatic run_scan(input int mode);
        logic [6:0]  a;
        logic        held;
        logic [6:0]  h_addr;
        logic [31:0] h_data;
        logic        h_last;
        int          cyc;
        int          first_v;
        logic        done;
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(7'(i));
`ifdef DBG_TEST_SCAN_EN
        for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(7'(32 + i));
`endif
        out_ready = (mode == 0);
        send_cmd(OP_SCAN);
        held = 1'b0; h_addr = '0; h_data = '0; h_last = 1'b0;
        first_v = -1; done = 1'b0; cyc = 0;
        while (!done && cyc < 3000) begin
            out_ready = (mode == 0) || (cyc % 3 == 2);
            if (exp_q.size() > 0) check("scan_debug_addr", debug_addr, exp_q[0]);
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (held) begin
                    check("stall_addr", out_addr, h_addr);
                    check("stall_data", out_data, h_data);
                    check("stall_last", out_last, h_last);
                end else begin
                    held = 1'b1; h_addr = out_addr; h_data = out_data; h_last = out_last;
                end
                if (out_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("beat_extra", 1, 0);
                        done = 1'b1;
                    end else begin
                        a = exp_q.pop_front();
                        check("beat_addr", out_addr, a);
                        check("beat_data", out_data, 32'hA500_0000 | {25'd0, a});
                        check("beat_last", out_last, exp_q.size() == 0);
                        if (out_last || exp_q.size() == 0) done = 1'b1;
                    end
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check("scan_first_valid", 64'(first_v), SETTLE_CYCLES + 1);
        check("scan_beats_left", exp_q.size(), 0);
        check("scan_end_busy", busy, 0);
        check("scan_end_debug_addr", debug_addr, 0);
        check("scan_end_out_valid", out_valid, 0);
        check("scan_end_out_last", out_last, 0);
        check("scan_end_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] step_v;
        logic [11:0] busy_v;
        int n;
        int hs;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_debug_en", debug_en, 0);
        check("rst_debug_step", debug_step, 0);
        check("rst_debug_addr", debug_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);

        // HALT then STEP
        send_cmd(OP_HALT);
        check("halt_debug_en", debug_en, 1);
        check("halt_busy", busy, 0);
        send_cmd(OP_STEP);
        check("step_cmd_ready_busy", cmd_ready, 0);
        watch_step(step_v, busy_v);
        check("step_pulse_pattern", step_v, 12'h00F);
        check("step_busy_pattern", busy_v, 12'h0FF);
        check("step_debug_en_kept", debug_en, 1);

        // A command held during a step waits for IDLE
        send_cmd(OP_STEP);
        cmd_valid = 1'b1;
        cmd_op    = OP_RUN;
        n = 0;
        while (!cmd_ready && n < 50) begin
            check("held_debug_en", debug_en, 1);
            tick();
            n++;
        end
        check("held_wait_cycles", n, 2 * STEP_PULSE);
        tick();
        cmd_valid = 1'b0;
        check("run_debug_en", debug_en, 0);
        check("run_busy", busy, 0);

        // STEP while running is ignored
        send_cmd(OP_STEP);
        watch_step(step_v, busy_v);
        check("step_run_pulse", step_v, 12'h000);
        check("step_run_busy", busy_v, 12'h000);

        // Scans: free-flowing and back-pressured
        run_scan(0);
        run_scan(1);

        // Reset in the middle of a scan, stalled at beat 3
        send_cmd(OP_HALT);
        out_ready = 1'b1;
        send_cmd(OP_SCAN);
        n = 0; hs = 0;
        while (hs < 3 && n < 500) begin
            if (out_valid && out_ready) hs++;
            tick();
            n++;
        end
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("midrst_beat3_valid", out_valid, 1);
        check("midrst_beat3_addr", out_addr, 3);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_debug_addr", debug_addr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_debug_en", debug_en, 0);
        check("midrst_out_addr", out_addr, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_last", out_last, 0);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_busy_after", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
